friet_c_lwc_buffer_out: RTL and testbench

//   Output-side elastic buffer between the FRIET-C core result path and the LWC do_ port.
//   Two-entry skid buffer: full throughput (1 word/cycle), in-order delivery.
//   din_ready is driven from state registers only, so there is no combinational dout_ready->din_ready path.

---
 rtl/friet_c_lwc_buffer_out_pkg.sv | 11 +
 rtl/friet_c_lwc_buffer_out_slot.sv | 23 ++
 rtl/friet_c_lwc_buffer_out.sv | 117 +++++++++++
 tb/tb_friet_c_lwc_buffer_out.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/friet_c_lwc_buffer_out_pkg.sv
// Shared definitions for the FRIET-C LWC output buffer.
// Occupancy encodings are shared with the input buffer checks and the LWC controller.
package friet_c_lwc_buffer_out_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,  // no word held
      ST_ONE   = 2'd1,  // main slot valid
      ST_TWO   = 2'd2   // main and skid slots valid
   } state_e;

endpackage

// File: rtl/friet_c_lwc_buffer_out_slot.sv
// One storage slot of the output buffer: a load-enabled register.
// It holds {last, data} as a single vector.
module friet_c_lwc_buffer_out_slot #(
   parameter int G_WIDTH = 33
) (
   input  logic               clk,
   input  logic               load_i,
   input  logic [G_WIDTH-1:0] d_i,
   output logic [G_WIDTH-1:0] q_o
);

   logic [G_WIDTH-1:0] data_q;

   // Capture d_i when load_i is high, otherwise hold.
   // NOTE: the data path is deliberately unreset; the occupancy state alone
   // decides whether a word is valid, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (load_i) data_q <= d_i;
   end

   assign q_o = data_q;

endmodule

// File: rtl/friet_c_lwc_buffer_out.sv
// Output-side elastic buffer between the FRIET-C result path and the LWC do_ port.
// Two-entry skid buffer: one word per cycle and in-order delivery. din_ready comes
// from the occupancy register only, so dout_ready has no combinational path to it.
module friet_c_lwc_buffer_out
   import friet_c_lwc_buffer_out_pkg::*;
#(
   parameter int G_WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [G_WIDTH-1:0] din,
   input  logic               din_last,
   input  logic               din_valid,
   output logic               din_ready,
   output logic [G_WIDTH-1:0] dout,
   output logic               dout_last,
   output logic               dout_valid,
   input  logic               dout_ready,
   output logic               idle
);

   state_e           state_q;
   state_e           state_d;
   logic             push;
   logic             pop;
   logic             main_load;
   logic             main_from_skid;
   logic             skid_load;
   logic [G_WIDTH:0] in_word;
   logic [G_WIDTH:0] main_d;
   logic [G_WIDTH:0] main_q;
   logic [G_WIDTH:0] skid_q;

   // Occupancy register; reset discards any buffered words immediately.
   // NOTE: sequential state is written with non-blocking assignments so every
   // flop samples the pre-edge values, independent of process ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_EMPTY;
      else      state_q <= state_d;
   end

   assign push = din_valid & din_ready;
   assign pop  = dout_valid & dout_ready;

   // Next occupancy. Ternaries keep an unknown push/pop visible as an unknown state.
   // NOTE: every combinational output gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_d = ST_EMPTY;
      case (state_q)
         ST_EMPTY: state_d = push ? ST_ONE : ST_EMPTY;
         ST_ONE:   state_d = push ? (pop ? ST_ONE : ST_TWO)
                                  : (pop ? ST_EMPTY : ST_ONE);
         ST_TWO:   state_d = pop ? ST_ONE : ST_TWO;
         default:  state_d = ST_EMPTY;  // unused encoding recovers to empty
      endcase
   end

   // Handshake outputs and slot load controls decoded from the occupancy state.
   always_comb begin
      din_ready      = 1'b0;
      dout_valid     = 1'b0;
      idle           = 1'b1;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            din_ready = rst;
            main_load = din_valid & rst;
         end
         ST_ONE: begin
            din_ready  = rst;
            dout_valid = 1'b1;
            idle       = 1'b0;
            // Refill main when it drains in the same cycle, otherwise park in skid.
            main_load  = din_valid & rst & dout_ready;
            skid_load  = din_valid & rst & ~dout_ready;
         end
         ST_TWO: begin
            dout_valid     = 1'b1;
            idle           = 1'b0;
            main_load      = dout_ready;
            main_from_skid = 1'b1;
         end
         default: begin
            // Unused encoding presents as empty; the next edge returns to ST_EMPTY.
            din_ready = rst;
         end
      endcase
   end

   assign in_word = {din_last, din};
   assign main_d  = main_from_skid ? skid_q : in_word;

   friet_c_lwc_buffer_out_slot #(
      .G_WIDTH (G_WIDTH + 1)
   ) u_main (
      .clk    (clk),
      .load_i (main_load),
      .d_i    (main_d),
      .q_o    (main_q)
   );

   friet_c_lwc_buffer_out_slot #(
      .G_WIDTH (G_WIDTH + 1)
   ) u_skid (
      .clk    (clk),
      .load_i (skid_load),
      .d_i    (in_word),
      .q_o    (skid_q)
   );

   assign dout      = main_q[G_WIDTH-1:0];
   assign dout_last = main_q[G_WIDTH];

endmodule

// File: tb/tb_friet_c_lwc_buffer_out.sv
// Testbench for the FRIET-C LWC output buffer.
// Stimulus queues expected words as they are offered into a free buffer; the
// monitor checks handshake outputs against an occupancy model and pops words in order.
module tb_friet_c_lwc_buffer_out;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] din;
   logic         din_last;
   logic         din_valid;
   logic         din_ready;
   logic [W-1:0] dout;
   logic         dout_last;
   logic         dout_valid;
   logic         dout_ready;
   logic         idle;

   int           n_checks = 0;
   int           n_errors = 0;
   int           n_pops   = 0;
   int           model_cnt = 0;
   logic         prev_hold = 1'b0;
   logic [W:0]   prev_word = '0;
   logic [W:0]   sb_q[$];
   logic         push_m;
   logic         pop_m;

   friet_c_lwc_buffer_out #(
      .G_WIDTH (W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_last   (din_last),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .dout       (dout),
      .dout_last  (dout_last),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .idle       (idle)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model decisions for the coming clock edge, from the model's own occupancy.
   assign push_m = rst && din_valid && (model_cnt < 2);
   assign pop_m  = rst && (model_cnt != 0) && dout_ready;

   // Monitor: checks flags every cycle, pops/compares delivered words, tracks stability.
   always @(negedge clk) begin
      if (!rst) begin
         check("rst_dout_valid", {63'd0, dout_valid}, 64'd0);
         check("rst_idle",       {63'd0, idle},       64'd1);
         check("rst_din_ready",  {63'd0, din_ready},  64'd0);
         sb_q.delete();
         model_cnt <= 0;
         prev_hold <= 1'b0;
      end else begin
         check("din_ready",  {63'd0, din_ready},  {63'd0, model_cnt < 2});
         check("dout_valid", {63'd0, dout_valid}, {63'd0, model_cnt != 0});
         check("idle",       {63'd0, idle},       {63'd0, model_cnt == 0});
         if (prev_hold && (model_cnt != 0))
            check("stable", {31'd0, dout_last, dout}, {31'd0, prev_word});
         if (pop_m) begin
            if (sb_q.size() == 0) begin
               check("sb_nonempty", 64'(sb_q.size()), 64'd1);
            end else begin
               check("sb_word", {31'd0, dout_last, dout}, {31'd0, sb_q[0]});
               void'(sb_q.pop_front());
            end
            n_pops <= n_pops + 1;
         end
         if (push_m) sb_q.push_back({din_last, din});
         model_cnt <= model_cnt + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
         prev_hold <= (model_cnt != 0) && !dout_ready;
         prev_word <= {dout_last, dout};
      end
   end

   // Apply one cycle of stimulus just after the rising edge.
   task automatic cyc(input logic v, input logic [W-1:0] d, input logic l, input logic r);
      @(posedge clk);
      #1;
      din_valid  = v;
      din        = d;
      din_last   = l;
      dout_ready = r;
   endtask

   // Offer one word, holding it until accepted; dout_ready is randomised each cycle.
   task automatic send_hold(input logic [W-1:0] d, input logic l);
      int k = 0;
      cyc(1'b1, d, l, 1'($urandom_range(0, 1)));
      forever begin
         @(negedge clk);
         if (push_m || k >= 50) break;
         @(posedge clk);
         #1;
         dout_ready = 1'($urandom_range(0, 1));
         k++;
      end
      check("send_accepted", {63'd0, k < 50}, 64'd1);
   endtask

   // Stop offering and let everything drain, then confirm idle.
   task automatic drain(input string name);
      int k = 0;
      cyc(1'b0, '0, 1'b0, 1'b1);
      while ((model_cnt != 0) && (k < 100)) begin
         @(posedge clk);
         k++;
      end
      check({name, "_drain_cnt"}, 64'(model_cnt), 64'd0);
      @(negedge clk);
      check({name, "_idle"}, {63'd0, idle}, 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      logic r;
      rst        = 1'b0;
      din        = '0;
      din_last   = 1'b0;
      din_valid  = 1'b0;
      dout_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;

      // Streaming: 1..16 back to back, one word per cycle after one-cycle latency.
      @(negedge clk);
      check("init_din_ready", {63'd0, din_ready}, 64'd1);
      p0 = n_pops;
      for (int i = 1; i <= 16; i++) cyc(1'b1, W'(i), 1'b0, 1'b1);
      cyc(1'b0, '0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      check("stream_pops", 64'(n_pops - p0), 64'd16);
      drain("stream");

      // Skid: two words with the sink stalled fill both slots.
      cyc(1'b1, 32'hA, 1'b0, 1'b0);
      cyc(1'b1, 32'hB, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0);
      @(negedge clk);
      check("skid_din_ready", {63'd0, din_ready}, 64'd0);
      check("skid_hold_a", 64'(dout), 64'hA);
      cyc(1'b0, '0, 1'b0, 1'b1);
      @(negedge clk);
      check("skid_out_a", 64'(dout), 64'hA);
      cyc(1'b0, '0, 1'b0, 1'b1);
      @(negedge clk);
      check("skid_out_b", 64'(dout), 64'hB);
      check("skid_out_b_valid", {63'd0, dout_valid}, 64'd1);
      drain("skid");

      // Last flag travels only with 0x33.
      send_hold(32'h11, 1'b0);
      send_hold(32'h22, 1'b0);
      send_hold(32'h33, 1'b1);
      drain("last");

      // Simultaneous push and pop in ONE replaces main.
      cyc(1'b1, 32'h55, 1'b0, 1'b0);
      cyc(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
      cyc(1'b0, '0, 1'b0, 1'b0);
      @(negedge clk);
      check("pp_dout",      64'(dout),            64'hFFFF_FFFF);
      check("pp_dout_last", {63'd0, dout_last},   64'd1);
      check("pp_din_ready", {63'd0, din_ready},   64'd1);
      drain("pp");

      // Random traffic; periodically toggle dout_ready mid-cycle and confirm
      // din_ready does not follow it.
      for (int i = 0; i < 10000; i++) begin
         r = 1'($urandom_range(0, 3) != 0);
         cyc(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)), r);
         if ((i % 16) == 5) begin
            logic dr0;
            dout_ready = ~r;
            #1;
            dr0 = din_ready;
            dout_ready = r;
            #1;
            check("din_ready_registered", {63'd0, din_ready}, {63'd0, dr0});
         end
      end
      drain("rand");

      // Reset with two words held: outputs clear at once, nothing stale afterwards.
      cyc(1'b1, 32'h100, 1'b0, 1'b0);
      cyc(1'b1, 32'h200, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("pre_rst_full", {63'd0, din_ready}, 64'd0);
      rst = 1'b0;
      #1;
      check("rst_now_valid",     {63'd0, dout_valid}, 64'd0);
      check("rst_now_idle",      {63'd0, idle},       64'd1);
      check("rst_now_din_ready", {63'd0, din_ready},  64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst        = 1'b1;
      dout_ready = 1'b1;
      @(negedge clk);
      check("post_rst_din_ready", {63'd0, din_ready}, 64'd1);
      repeat (5) begin
         @(negedge clk);
         check("post_rst_no_stale", {63'd0, dout_valid}, 64'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
